mcpu_ctrl_int: RTL and testbench

- Multi-cycle control unit driving the single-bus multi-cycle datapath: PC, IR, MDR, regfile, ALU, ALUOut, and the PC/address/writeback muxes.
- Successor to the fixed five-phase controller. Adds memory wait-state stalling on MIO_ready, bne/jal/jr, a vectored interrupt with EPC save, and eret.
- Outputs are a registered state plus Moore-decoded control; branch condition is Mealy on zero.

---
 rtl/mcpu_ctrl_int_if.sv | 49 ++++
 rtl/mcpu_ctrl_int.sv | 217 +++++++++++++++++++++
 tb/tb_mcpu_ctrl_int.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mcpu_ctrl_int_if.sv
// Control bundle between the multi-cycle controller and its datapath.
// master: controller side (takes IR fields and status flags, drives control).
// slave : datapath side (drives IR fields and status flags, takes control).
interface mcpu_ctrl_int_if;
    localparam int unsigned OP_W  = 6;
    localparam int unsigned ST_W  = 5;
    localparam int unsigned ALU_W = 4;

    // Status from the datapath and memory
    logic [OP_W-1:0]  op;
    logic [OP_W-1:0]  funct;
    logic             zero;
    logic             mio_ready;
    logic             int_req;

    // Control to the datapath
    logic             pc_write;
    logic             pc_write_cond;
    logic             branch;
    logic [1:0]       pc_src;
    logic             exc_sel;
    logic             epc_write;
    logic             iord;
    logic             mem_w;
    logic             cpu_mio;
    logic             ir_write;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [ALU_W-1:0] alu_ctrl;
    logic             ie;
    logic [ST_W-1:0]  state;

    modport master (
        input  op, funct, zero, mio_ready, int_req,
        output pc_write, pc_write_cond, branch, pc_src, exc_sel, epc_write,
               iord, mem_w, cpu_mio, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_ctrl, ie, state
    );

    modport slave (
        output op, funct, zero, mio_ready, int_req,
        input  pc_write, pc_write_cond, branch, pc_src, exc_sel, epc_write,
               iord, mem_w, cpu_mio, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_ctrl, ie, state
    );
endinterface

// File: rtl/mcpu_ctrl_int.sv
// Multi-cycle controller for the single-bus datapath with memory wait
// states, bne/jal/jr, a vectored interrupt with EPC save, and eret.
// Ports: clk, reset (async, active-high), bus (mcpu_ctrl_int_if.master):
//   op/funct/zero/mio_ready/int_req in; PC, memory, IR, regfile and ALU
//   control, ie flag and current state code out.
// Control is Moore-decoded from the state register; branch is Mealy on zero,
// and IF/MR/MW completion strobes follow mio_ready within the cycle.
module mcpu_ctrl_int #(
    parameter bit INT_EN   = 1'b1,
    parameter bit MEM_WAIT = 1'b1,
    parameter bit ILL_TRAP = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    mcpu_ctrl_int_if.master  bus
);
    localparam logic [4:0] S_IF   = 5'd0;
    localparam logic [4:0] S_ID   = 5'd1;
    localparam logic [4:0] S_MA   = 5'd2;
    localparam logic [4:0] S_MR   = 5'd3;
    localparam logic [4:0] S_LWB  = 5'd4;
    localparam logic [4:0] S_MW   = 5'd5;
    localparam logic [4:0] S_REX  = 5'd6;
    localparam logic [4:0] S_RWB  = 5'd7;
    localparam logic [4:0] S_BR   = 5'd8;
    localparam logic [4:0] S_J    = 5'd9;
    localparam logic [4:0] S_IEX  = 5'd10;
    localparam logic [4:0] S_IWB  = 5'd11;
    localparam logic [4:0] S_JAL  = 5'd12;
    localparam logic [4:0] S_JR   = 5'd13;
    localparam logic [4:0] S_INT  = 5'd14;
    localparam logic [4:0] S_ERET = 5'd15;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    logic [4:0] state_q, state_d;
    logic       ie_q, ie_d;
    logic       mem_go;
    logic [4:0] id_tgt;
    logic [3:0] rex_alu;

    // Memory access finishes this cycle (always, when wait states are off)
    assign mem_go = bus.mio_ready | ~MEM_WAIT;

    // Instruction decode target out of ID
    always_comb begin
        id_tgt = ILL_TRAP ? S_INT : S_IF;
        case (bus.op)
            6'b000000: begin
                case (bus.funct)
                    6'b100000, 6'b100010, 6'b100100,
                    6'b100101, 6'b101010: id_tgt = S_REX;
                    6'b001000:            id_tgt = S_JR;
                    default:              ;
                endcase
            end
            6'b100011, 6'b101011: id_tgt = S_MA;
            6'b001000:            id_tgt = S_IEX;
            6'b000100, 6'b000101: id_tgt = S_BR;
            6'b000010:            id_tgt = S_J;
            6'b000011:            id_tgt = S_JAL;
            6'b010000: begin
                if (INT_EN && (bus.funct == 6'b011000)) id_tgt = S_ERET;
            end
            default:              ;
        endcase
    end

    // R-type ALU operation from funct
    always_comb begin
        rex_alu = ALU_ADD;
        case (bus.funct)
            6'b100010: rex_alu = ALU_SUB;
            6'b100100: rex_alu = ALU_AND;
            6'b100101: rex_alu = ALU_OR;
            6'b101010: rex_alu = ALU_SLT;
            default:   ;
        endcase
    end

    // Next state and interrupt-enable update
    always_comb begin
        state_d = S_IF;
        ie_d    = ie_q;
        case (state_q)
            S_IF:   state_d = mem_go ? S_ID : S_IF;
            S_ID:   state_d = id_tgt;
            S_MA:   state_d = bus.op[3] ? S_MW : S_MR;
            S_MR:   state_d = mem_go ? S_LWB : S_MR;
            S_MW:   state_d = mem_go ? S_IF : S_MW;
            S_REX:  state_d = S_RWB;
            S_IEX:  state_d = S_IWB;
            S_INT:  ie_d    = 1'b0;
            S_ERET: ie_d    = 1'b1;
            default: ;
        endcase
        // Interrupts are sampled only on entry into IF. INT->IF is excluded
        // because ie_q is still 1 in that cycle; it clears on the same edge.
        if (INT_EN && ie_q && bus.int_req && (state_d == S_IF) &&
            (state_q != S_IF) && (state_q != S_INT))
            state_d = S_INT;
    end

    // Moore control decode; everything held at defaults during reset
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.branch        = 1'b0;
        bus.pc_src        = 2'd0;
        bus.exc_sel       = 1'b0;
        bus.epc_write     = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_w         = 1'b0;
        bus.cpu_mio       = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_dst       = 2'd0;
        bus.mem_to_reg    = 2'd0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'd0;
        bus.alu_ctrl      = ALU_ADD;
        if (!reset) begin
            case (state_q)
                S_IF: begin
                    bus.cpu_mio   = 1'b1;
                    bus.alu_src_b = 2'd1;
                    bus.ir_write  = mem_go;
                    bus.pc_write  = mem_go;
                end
                S_ID:  bus.alu_src_b = 2'd3;
                S_MA: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'd2;
                end
                S_MR: begin
                    bus.cpu_mio = 1'b1;
                    bus.iord    = 1'b1;
                end
                S_LWB: begin
                    bus.mem_to_reg = 2'd1;
                    bus.reg_write  = 1'b1;
                end
                S_MW: begin
                    bus.cpu_mio = 1'b1;
                    bus.iord    = 1'b1;
                    bus.mem_w   = 1'b1;
                end
                S_REX: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_ctrl  = rex_alu;
                end
                S_RWB: begin
                    bus.reg_dst   = 2'd1;
                    bus.reg_write = 1'b1;
                end
                S_BR: begin
                    bus.alu_src_a     = 1'b1;
                    bus.alu_ctrl      = ALU_SUB;
                    bus.pc_write_cond = 1'b1;
                    bus.pc_src        = 2'd1;
                    bus.branch        = bus.op[0] ? ~bus.zero : bus.zero;
                end
                S_J: begin
                    bus.pc_src   = 2'd2;
                    bus.pc_write = 1'b1;
                end
                S_IEX: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'd2;
                end
                S_IWB: bus.reg_write = 1'b1;
                S_JAL: begin
                    bus.reg_dst    = 2'd2;
                    bus.mem_to_reg = 2'd2;
                    bus.reg_write  = 1'b1;
                    bus.pc_src     = 2'd2;
                    bus.pc_write   = 1'b1;
                end
                // rt is $0, so OR passes rs straight to the PC
                S_JR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_ctrl  = ALU_OR;
                    bus.pc_write  = 1'b1;
                end
                S_INT: begin
                    bus.epc_write = 1'b1;
                    bus.pc_src    = 2'd3;
                    bus.pc_write  = 1'b1;
                end
                S_ERET: begin
                    bus.pc_src   = 2'd3;
                    bus.exc_sel  = 1'b1;
                    bus.pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State and ie registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IF;
            ie_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            ie_q    <= ie_d;
        end
    end

    assign bus.state = state_q;
    assign bus.ie    = ie_q;
endmodule

// File: tb/tb_mcpu_ctrl_int.sv
// Directed, table-driven bench for mcpu_ctrl_int: one record per clock cycle
// with inputs and expected state/control/ie, plus a reset-during-MW sequence.
module tb_mcpu_ctrl_int;
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch;
        logic [1:0] pc_src;
        logic       exc_sel;
        logic       epc_write;
        logic       iord;
        logic       mem_w;
        logic       cpu_mio;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctrl;
    } ctl_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       rdy;
        logic       irq;
        logic [4:0] st;
        ctl_t       ctl;
        logic       ie;
    } vec_t;

    localparam ctl_t C_DEF      = '{alu_ctrl: 4'b0010, default: '0};
    localparam ctl_t C_IF_RDY   = '{pc_write: 1'b1, cpu_mio: 1'b1, ir_write: 1'b1,
                                    alu_src_b: 2'd1, alu_ctrl: 4'b0010, default: '0};
    localparam ctl_t C_IF_STALL = '{cpu_mio: 1'b1, alu_src_b: 2'd1, alu_ctrl: 4'b0010,
                                    default: '0};
    localparam ctl_t C_ID       = '{alu_src_b: 2'd3, alu_ctrl: 4'b0010, default: '0};
    localparam ctl_t C_MA       = '{alu_src_a: 1'b1, alu_src_b: 2'd2, alu_ctrl: 4'b0010,
                                    default: '0};
    localparam ctl_t C_MR       = '{cpu_mio: 1'b1, iord: 1'b1, alu_ctrl: 4'b0010,
                                    default: '0};
    localparam ctl_t C_LWB      = '{mem_to_reg: 2'd1, reg_write: 1'b1, alu_ctrl: 4'b0010,
                                    default: '0};
    localparam ctl_t C_MW       = '{cpu_mio: 1'b1, iord: 1'b1, mem_w: 1'b1,
                                    alu_ctrl: 4'b0010, default: '0};
    localparam ctl_t C_REX_ADD  = '{alu_src_a: 1'b1, alu_ctrl: 4'b0010, default: '0};
    localparam ctl_t C_REX_SUB  = '{alu_src_a: 1'b1, alu_ctrl: 4'b0110, default: '0};
    localparam ctl_t C_RWB      = '{reg_dst: 2'd1, reg_write: 1'b1, alu_ctrl: 4'b0010,
                                    default: '0};
    localparam ctl_t C_BR_T     = '{alu_src_a: 1'b1, alu_ctrl: 4'b0110, pc_write_cond: 1'b1,
                                    pc_src: 2'd1, branch: 1'b1, default: '0};
    localparam ctl_t C_BR_NT    = '{alu_src_a: 1'b1, alu_ctrl: 4'b0110, pc_write_cond: 1'b1,
                                    pc_src: 2'd1, default: '0};
    localparam ctl_t C_J        = '{pc_src: 2'd2, pc_write: 1'b1, alu_ctrl: 4'b0010,
                                    default: '0};
    localparam ctl_t C_IEX      = '{alu_src_a: 1'b1, alu_src_b: 2'd2, alu_ctrl: 4'b0010,
                                    default: '0};
    localparam ctl_t C_IWB      = '{reg_write: 1'b1, alu_ctrl: 4'b0010, default: '0};
    localparam ctl_t C_JAL      = '{reg_dst: 2'd2, mem_to_reg: 2'd2, reg_write: 1'b1,
                                    pc_src: 2'd2, pc_write: 1'b1, alu_ctrl: 4'b0010,
                                    default: '0};
    localparam ctl_t C_JR       = '{alu_src_a: 1'b1, alu_ctrl: 4'b0001, pc_write: 1'b1,
                                    default: '0};
    localparam ctl_t C_INT      = '{epc_write: 1'b1, pc_src: 2'd3, pc_write: 1'b1,
                                    alu_ctrl: 4'b0010, default: '0};
    localparam ctl_t C_ERET     = '{pc_src: 2'd3, exc_sel: 1'b1, pc_write: 1'b1,
                                    alu_ctrl: 4'b0010, default: '0};

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    vec_t vecs[$];

    mcpu_ctrl_int_if bus ();

    mcpu_ctrl_int dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t act_ctl();
        ctl_t c;
        c.pc_write      = bus.pc_write;
        c.pc_write_cond = bus.pc_write_cond;
        c.branch        = bus.branch;
        c.pc_src        = bus.pc_src;
        c.exc_sel       = bus.exc_sel;
        c.epc_write     = bus.epc_write;
        c.iord          = bus.iord;
        c.mem_w         = bus.mem_w;
        c.cpu_mio       = bus.cpu_mio;
        c.ir_write      = bus.ir_write;
        c.reg_dst       = bus.reg_dst;
        c.mem_to_reg    = bus.mem_to_reg;
        c.reg_write     = bus.reg_write;
        c.alu_src_a     = bus.alu_src_a;
        c.alu_src_b     = bus.alu_src_b;
        c.alu_ctrl      = bus.alu_ctrl;
        return c;
    endfunction

    task automatic cmp(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, got, want);
        end
    endtask

    task automatic row(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                       input logic rdy, input logic irq, input logic [4:0] st,
                       input ctl_t ctl, input logic ie);
        vec_t v;
        v.op = op; v.funct = funct; v.zero = zero; v.rdy = rdy; v.irq = irq;
        v.st = st; v.ctl = ctl; v.ie = ie;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] funct, input logic zero,
                         input logic rdy, input logic irq);
        bus.op = op; bus.funct = funct; bus.zero = zero;
        bus.mio_ready = rdy; bus.int_req = irq;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        drive(6'h00, 6'h00, 1'b0, 1'b1, 1'b0);

        // add
        row(6'h00, 6'h00, 0, 1, 0, 5'd0, C_IF_RDY, 1);
        row(6'h00, 6'h20, 0, 1, 0, 5'd1, C_ID, 1);
        row(6'h00, 6'h20, 0, 1, 0, 5'd6, C_REX_ADD, 1);
        row(6'h00, 6'h20, 0, 1, 0, 5'd7, C_RWB, 1);
        // lw with two MR wait states
        row(6'h00, 6'h00, 0, 1, 0, 5'd0, C_IF_RDY, 1);
        row(6'h23, 6'h00, 0, 1, 0, 5'd1, C_ID, 1);
        row(6'h23, 6'h00, 0, 1, 0, 5'd2, C_MA, 1);
        row(6'h23, 6'h00, 0, 0, 0, 5'd3, C_MR, 1);
        row(6'h23, 6'h00, 0, 0, 0, 5'd3, C_MR, 1);
        row(6'h23, 6'h00, 0, 1, 0, 5'd3, C_MR, 1);
        row(6'h23, 6'h00, 0, 1, 0, 5'd4, C_LWB, 1);
        // sw with one IF wait state
        row(6'h00, 6'h00, 0, 0, 0, 5'd0, C_IF_STALL, 1);
        row(6'h00, 6'h00, 0, 1, 0, 5'd0, C_IF_RDY, 1);
        row(6'h2B, 6'h00, 0, 1, 0, 5'd1, C_ID, 1);
        row(6'h2B, 6'h00, 0, 1, 0, 5'd2, C_MA, 1);
        row(6'h2B, 6'h00, 0, 1, 0, 5'd5, C_MW, 1);
        // sub
        row(6'h00, 6'h00, 0, 1, 0, 5'd0, C_IF_RDY, 1);
        row(6'h00, 6'h22, 0, 1, 0, 5'd1, C_ID, 1);
        row(6'h00, 6'h22, 0, 1, 0, 5'd6, C_REX_SUB, 1);
        row(6'h00, 6'h22, 0, 1, 0, 5'd7, C_RWB, 1);
        // beq taken, bne taken, bne not taken
        row(6'h00, 6'h00, 0, 1, 0, 5'd0, C_IF_RDY, 1);
        row(6'h04, 6'h00, 1, 1, 0, 5'd1, C_ID, 1);
        row(6'h04, 6'h00, 1, 1, 0, 5'd8, C_BR_T, 1);
        row(6'h00, 6'h00, 0, 1, 0, 5'd0, C_IF_RDY, 1);
        row(6'h05, 6'h00, 0, 1, 0, 5'd1, C_ID, 1);
        row(6'h05, 6'h00, 0, 1, 0, 5'd8, C_BR_T, 1);
        row(6'h00, 6'h00, 0, 1, 0, 5'd0, C_IF_RDY, 1);
        row(6'h05, 6'h00, 1, 1, 0, 5'd1, C_ID, 1);
        row(6'h05, 6'h00, 1, 1, 0, 5'd8, C_BR_NT, 1);
        // j, jal, jr, addi
        row(6'h00, 6'h00, 0, 1, 0, 5'd0, C_IF_RDY, 1);
        row(6'h02, 6'h00, 0, 1, 0, 5'd1, C_ID, 1);
        row(6'h02, 6'h00, 0, 1, 0, 5'd9, C_J, 1);
        row(6'h00, 6'h00, 0, 1, 0, 5'd0, C_IF_RDY, 1);
        row(6'h03, 6'h00, 0, 1, 0, 5'd1, C_ID, 1);
        row(6'h03, 6'h00, 0, 1, 0, 5'd12, C_JAL, 1);
        row(6'h00, 6'h00, 0, 1, 0, 5'd0, C_IF_RDY, 1);
        row(6'h00, 6'h08, 0, 1, 0, 5'd1, C_ID, 1);
        row(6'h00, 6'h08, 0, 1, 0, 5'd13, C_JR, 1);
        row(6'h00, 6'h00, 0, 1, 0, 5'd0, C_IF_RDY, 1);
        row(6'h08, 6'h00, 0, 1, 0, 5'd1, C_ID, 1);
        row(6'h08, 6'h00, 0, 1, 0, 5'd10, C_IEX, 1);
        row(6'h08, 6'h00, 0, 1, 0, 5'd11, C_IWB, 1);
        // interrupt raised in RWB, masked afterwards until eret
        row(6'h00, 6'h00, 0, 1, 0, 5'd0, C_IF_RDY, 1);
        row(6'h00, 6'h20, 0, 1, 0, 5'd1, C_ID, 1);
        row(6'h00, 6'h20, 0, 1, 0, 5'd6, C_REX_ADD, 1);
        row(6'h00, 6'h20, 0, 1, 1, 5'd7, C_RWB, 1);
        row(6'h00, 6'h20, 0, 1, 1, 5'd14, C_INT, 1);
        row(6'h00, 6'h00, 0, 1, 1, 5'd0, C_IF_RDY, 0);
        row(6'h02, 6'h00, 0, 1, 1, 5'd1, C_ID, 0);
        row(6'h02, 6'h00, 0, 1, 1, 5'd9, C_J, 0);
        row(6'h00, 6'h00, 0, 1, 1, 5'd0, C_IF_RDY, 0);
        row(6'h10, 6'h18, 0, 1, 0, 5'd1, C_ID, 0);
        row(6'h10, 6'h18, 0, 1, 0, 5'd15, C_ERET, 0);
        row(6'h00, 6'h00, 0, 1, 0, 5'd0, C_IF_RDY, 1);
        // illegal opcode traps, then eret back
        row(6'h3F, 6'h00, 0, 1, 0, 5'd1, C_ID, 1);
        row(6'h3F, 6'h00, 0, 1, 0, 5'd14, C_INT, 1);
        row(6'h00, 6'h00, 0, 1, 0, 5'd0, C_IF_RDY, 0);
        row(6'h10, 6'h18, 0, 1, 0, 5'd1, C_ID, 0);
        row(6'h10, 6'h18, 0, 1, 0, 5'd15, C_ERET, 0);
        row(6'h00, 6'h00, 0, 1, 0, 5'd0, C_IF_RDY, 1);
        // lead-in to sw for the reset-during-stall sequence
        row(6'h2B, 6'h00, 0, 1, 0, 5'd1, C_ID, 1);
        row(6'h2B, 6'h00, 0, 1, 0, 5'd2, C_MA, 1);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        cmp("rst_state", -1, 32'(bus.state), 32'd0);
        cmp("rst_ctl", -1, 32'(act_ctl()), 32'(C_DEF));
        cmp("rst_ie", -1, 32'(bus.ie), 32'd1);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].rdy, vecs[i].irq);
            #1;
            cmp("state", i, 32'(bus.state), 32'(vecs[i].st));
            cmp("ctl", i, 32'(act_ctl()), 32'(vecs[i].ctl));
            cmp("ie", i, 32'(bus.ie), 32'(vecs[i].ie));
        end

        // MW stalled, then asynchronous reset mid-cycle
        @(negedge clk);
        drive(6'h2B, 6'h00, 1'b0, 1'b0, 1'b0);
        #1;
        cmp("mw_state", 0, 32'(bus.state), 32'd5);
        cmp("mw_memw", 0, 32'(bus.mem_w), 32'd1);
        @(posedge clk);
        #1;
        cmp("mw_hold", 1, 32'(bus.state), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        cmp("arst_state", 0, 32'(bus.state), 32'd0);
        cmp("arst_memw", 0, 32'(bus.mem_w), 32'd0);
        cmp("arst_mio", 0, 32'(bus.cpu_mio), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(6'h00, 6'h00, 1'b0, 1'b1, 1'b0);
        #1;
        cmp("post_state", 0, 32'(bus.state), 32'd0);
        cmp("post_ctl", 0, 32'(act_ctl()), 32'(C_IF_RDY));
        cmp("post_ie", 0, 32'(bus.ie), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
